// File: rtl/rob_commit.sv
// In-order commit unit for the rob extract side: retires the longest legal head
// prefix, drives registered RF write ports and raises a precise-exception flush.

module rob_commit_lane #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] dest,
    output logic                      needs_port
);
    // r0 writes retire normally but never occupy a write port
    assign needs_port = wr_en && (dest != '0);
endmodule

module rob_commit #(
    parameter  int EXT_COUNT      = 4,
    parameter  int DATA_WIDTH     = 32,
    parameter  int REG_ADDR_WIDTH = 5,
    parameter  int PC_WIDTH       = 32,
    parameter  int RF_WR_PORTS    = 2,
    localparam int CNT_W          = $clog2(EXT_COUNT)
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic [EXT_COUNT-1:0]                       slot_valid,
    input  logic [EXT_COUNT-1:0][DATA_WIDTH-1:0]       slot_result,
    input  logic [EXT_COUNT-1:0][REG_ADDR_WIDTH-1:0]   slot_dest,
    input  logic [EXT_COUNT-1:0]                       slot_wr_en,
    input  logic [EXT_COUNT-1:0]                       slot_exc,
    input  logic [EXT_COUNT-1:0][PC_WIDTH-1:0]         slot_pc,
    input  logic                                       rob_empty,
    input  logic                                       commit_stall,
    output logic                                       consume,
    output logic [CNT_W-1:0]                           consume_count,
    output logic [RF_WR_PORTS-1:0]                     rf_we,
    output logic [RF_WR_PORTS-1:0][REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [RF_WR_PORTS-1:0][DATA_WIDTH-1:0]     rf_wdata,
    output logic                                       flush,
    output logic [PC_WIDTH-1:0]                        epc,
    output logic [CNT_W:0]                             commit_n,
    output logic [31:0]                                retired_total
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t state, state_nxt;

    logic [EXT_COUNT-1:0]                       needs_port;
    logic [RF_WR_PORTS-1:0]                     pw_en;
    logic [RF_WR_PORTS-1:0][REG_ADDR_WIDTH-1:0] pw_addr;
    logic [RF_WR_PORTS-1:0][DATA_WIDTH-1:0]     pw_data;
    logic [CNT_W:0]                             n_cnt;
    logic                                       exc_take;
    logic [PC_WIDTH-1:0]                        exc_pc;

    for (genvar g = 0; g < EXT_COUNT; g++) begin : g_lane
        rob_commit_lane #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_lane (
            .wr_en      (slot_wr_en[g]),
            .dest       (slot_dest[g]),
            .needs_port (needs_port[g])
        );
    end

    // Prefix scan: ports are handed out in program order until one runs short
    always_comb begin
        int  n_sel;
        int  ports_used;
        logic stop;
        n_sel      = 0;
        ports_used = 0;
        stop       = 1'b0;
        exc_take   = 1'b0;
        exc_pc     = '0;
        pw_en      = '0;
        pw_addr    = '0;
        pw_data    = '0;
        for (int i = 0; i < EXT_COUNT; i++) begin
            if (!stop) begin
                if (!slot_valid[i] || (slot_exc[i] && i != 0) ||
                    (needs_port[i] && ports_used == RF_WR_PORTS)) begin
                    stop = 1'b1;
                end else begin
                    n_sel = n_sel + 1;
                    if (slot_exc[i]) begin
                        stop     = 1'b1;
                        exc_take = 1'b1;
                        exc_pc   = slot_pc[i];
                    end else if (needs_port[i]) begin
                        for (int k = 0; k < RF_WR_PORTS; k++) begin
                            if (k == ports_used) begin
                                pw_en[k]   = 1'b1;
                                pw_addr[k] = slot_dest[i];
                                pw_data[k] = slot_result[i];
                            end
                        end
                        ports_used = ports_used + 1;
                    end
                end
            end
        end
        n_cnt = (CNT_W+1)'(n_sel);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (consume && exc_take) state_nxt = FLUSH;
            FLUSH:   if (rob_empty)           state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        consume       = (state == RUN) && !commit_stall && (n_cnt != '0);
        consume_count = consume ? CNT_W'(n_cnt - 1'b1) : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rf_we         <= '0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            flush         <= 1'b0;
            epc           <= '0;
            commit_n      <= '0;
            retired_total <= '0;
        end else begin
            rf_we    <= consume ? pw_en : '0;
            flush    <= consume && exc_take;
            commit_n <= consume ? n_cnt : '0;
            if (consume) retired_total <= retired_total + 32'(n_cnt);
            if (consume && exc_take) epc <= exc_pc;
            // idle ports keep their last address/data
            for (int k = 0; k < RF_WR_PORTS; k++) begin
                if (consume && pw_en[k]) begin
                    rf_waddr[k] <= pw_addr[k];
                    rf_wdata[k] <= pw_data[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: hand-computed expectations checked with
// immediate assertions along one linear stimulus sequence.

module tb_rob_commit;
    localparam int EXT_COUNT = 4;
    localparam int DW        = 32;
    localparam int AW        = 5;
    localparam int PW        = 32;
    localparam int NP        = 2;
    localparam int CW        = $clog2(EXT_COUNT);

    logic                             clock = 1'b0;
    logic                             reset_n;
    logic [EXT_COUNT-1:0]             slot_valid;
    logic [EXT_COUNT-1:0][DW-1:0]     slot_result;
    logic [EXT_COUNT-1:0][AW-1:0]     slot_dest;
    logic [EXT_COUNT-1:0]             slot_wr_en;
    logic [EXT_COUNT-1:0]             slot_exc;
    logic [EXT_COUNT-1:0][PW-1:0]     slot_pc;
    logic                             rob_empty;
    logic                             commit_stall;
    logic                             consume;
    logic [CW-1:0]                    consume_count;
    logic [NP-1:0]                    rf_we;
    logic [NP-1:0][AW-1:0]            rf_waddr;
    logic [NP-1:0][DW-1:0]            rf_wdata;
    logic                             flush;
    logic [PW-1:0]                    epc;
    logic [CW:0]                      commit_n;
    logic [31:0]                      retired_total;

    int compared   = 0;
    int mismatched = 0;

    rob_commit #(
        .EXT_COUNT(EXT_COUNT), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW),
        .PC_WIDTH(PW), .RF_WR_PORTS(NP)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .slot_valid(slot_valid), .slot_result(slot_result), .slot_dest(slot_dest),
        .slot_wr_en(slot_wr_en), .slot_exc(slot_exc), .slot_pc(slot_pc),
        .rob_empty(rob_empty), .commit_stall(commit_stall),
        .consume(consume), .consume_count(consume_count),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush(flush), .epc(epc), .commit_n(commit_n), .retired_total(retired_total)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        slot_valid  = '0;
        slot_result = '0;
        slot_dest   = '0;
        slot_wr_en  = '0;
        slot_exc    = '0;
        slot_pc     = '0;
    endtask

    initial begin
        clr();
        reset_n      = 1'b0;
        rob_empty    = 1'b0;
        commit_stall = 1'b0;
        tick(); tick();

        chk("rst_rf_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_flush", flush, 0);
        chk("rst_epc", epc, 0);
        chk("rst_commit_n", commit_n, 0);
        chk("rst_retired", retired_total, 0);
        chk("rst_consume", consume, 0);
        reset_n = 1'b1;
        tick();

        // Four writers, two ports: first pair
        slot_valid = 4'b1111; slot_wr_en = 4'b1111;
        slot_dest[0] = 5'd1; slot_dest[1] = 5'd2; slot_dest[2] = 5'd3; slot_dest[3] = 5'd4;
        slot_result[0] = 32'hAAAA_0001; slot_result[1] = 32'hBBBB_0002;
        slot_result[2] = 32'hCCCC_0003; slot_result[3] = 32'hDDDD_0004;
        #1;
        chk("t1_consume", consume, 1);
        chk("t1_count", consume_count, 1);
        tick();
        chk("t1_we", rf_we, 2'b11);
        chk("t1_waddr0", rf_waddr[0], 1);
        chk("t1_waddr1", rf_waddr[1], 2);
        chk("t1_wdata0", rf_wdata[0], 32'hAAAA_0001);
        chk("t1_wdata1", rf_wdata[1], 32'hBBBB_0002);
        chk("t1_commit_n", commit_n, 2);
        // remaining two shift to the head
        clr();
        slot_valid = 4'b0011; slot_wr_en = 4'b0011;
        slot_dest[0] = 5'd3; slot_dest[1] = 5'd4;
        slot_result[0] = 32'hCCCC_0003; slot_result[1] = 32'hDDDD_0004;
        #1;
        chk("t1b_count", consume_count, 1);
        tick();
        chk("t1b_we", rf_we, 2'b11);
        chk("t1b_waddr0", rf_waddr[0], 3);
        chk("t1b_waddr1", rf_waddr[1], 4);
        chk("t1b_wdata1", rf_wdata[1], 32'hDDDD_0004);
        chk("t1b_retired", retired_total, 4);

        // Single writer in slot 2
        clr();
        slot_valid = 4'b1111; slot_wr_en = 4'b0100;
        slot_dest[2] = 5'd7; slot_result[2] = 32'h55;
        #1;
        chk("t2_count", consume_count, 3);
        tick();
        chk("t2_we", rf_we, 2'b01);
        chk("t2_waddr0", rf_waddr[0], 7);
        chk("t2_wdata0", rf_wdata[0], 32'h55);
        chk("t2_waddr1_hold", rf_waddr[1], 4);
        chk("t2_commit_n", commit_n, 4);
        chk("t2_retired", retired_total, 8);

        // Hole at slot 1; head writes r0
        clr();
        slot_valid = 4'b1101; slot_wr_en = 4'b0001; slot_dest[0] = 5'd0;
        slot_result[0] = 32'hDEAD;
        #1;
        chk("t3_consume", consume, 1);
        chk("t3_count", consume_count, 0);
        tick();
        chk("t3_we", rf_we, 0);
        chk("t3_commit_n", commit_n, 1);
        chk("t3_waddr0_hold", rf_waddr[0], 7);
        chk("t3_retired", retired_total, 9);

        // Exception in slot 2 limits commit to two
        clr();
        slot_valid = 4'b1111; slot_exc = 4'b0100; slot_pc[2] = 32'h40;
        #1;
        chk("t4_count", consume_count, 1);
        tick();
        chk("t4_commit_n", commit_n, 2);
        chk("t4_retired", retired_total, 11);
        // Faulting entry now at head, also flagged as a writer
        clr();
        slot_valid = 4'b1111; slot_exc = 4'b0001; slot_pc[0] = 32'h40;
        slot_wr_en = 4'b0001; slot_dest[0] = 5'd9; slot_result[0] = 32'h99;
        #1;
        chk("t4_exc_consume", consume, 1);
        chk("t4_exc_count", consume_count, 0);
        tick();
        chk("t4_flush", flush, 1);
        chk("t4_epc", epc, 32'h40);
        chk("t4_no_write", rf_we, 0);
        chk("t4_exc_commit_n", commit_n, 1);
        chk("t4_exc_retired", retired_total, 12);
        chk("t4_pulse_consume", consume, 0);
        clr();
        slot_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t4_flush_low", flush, 0);
            chk("t4_wait_consume", consume, 0);
        end
        rob_empty = 1'b1;
        #1;
        chk("t4_empty_consume", consume, 0);
        tick();
        rob_empty = 1'b0;
        #1;
        chk("t4_resume_consume", consume, 1);
        chk("t4_resume_count", consume_count, 3);
        tick();
        chk("t4_resume_commit_n", commit_n, 4);
        chk("t4_resume_retired", retired_total, 16);
        chk("t4_epc_held", epc, 32'h40);

        // Stall for five cycles
        commit_stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t5_stall_consume", consume, 0);
            chk("t5_stall_count", consume_count, 0);
            tick();
            chk("t5_stall_commit_n", commit_n, 0);
        end
        commit_stall = 1'b0;
        #1;
        chk("t5_unstall_consume", consume, 1);
        tick();
        chk("t5_commit_n", commit_n, 4);
        chk("t5_retired", retired_total, 20);

        // Counter wrap
        clr();
        force dut.retired_total = 32'hFFFF_FFFE;
        #1;
        release dut.retired_total;
        tick();
        chk("t6_preload", retired_total, 32'hFFFF_FFFE);
        slot_valid = 4'b1111;
        tick();
        chk("t6_wrap", retired_total, 32'h0000_0002);

        // Reset during the flush pulse
        clr();
        slot_valid = 4'b0001; slot_exc = 4'b0001; slot_pc[0] = 32'h80;
        tick();
        chk("t7_flush", flush, 1);
        chk("t7_epc", epc, 32'h80);
        reset_n = 1'b0;
        tick();
        chk("t7_rst_flush", flush, 0);
        chk("t7_rst_epc", epc, 0);
        chk("t7_rst_retired", retired_total, 0);
        chk("t7_rst_commit_n", commit_n, 0);
        clr();
        reset_n = 1'b1;
        tick();
        chk("t7_no_pulse", flush, 0);
        slot_valid = 4'b1111;
        #1;
        chk("t7_run_consume", consume, 1);
        tick();
        chk("t7_retired", retired_total, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
